// File: rtl/asip_pkg.sv
// rtl/asip_pkg.sv - shared types and constants for the multicycle ASIP core
//
// Purpose: instruction field positions, instruction width, opcode and FSM
//          state encodings used by asip_mc and asip_regfile.
// Ports:   none (package).

package asip_pkg;

  localparam int INST_W  = 24;

  localparam int OP_MSB  = 23;
  localparam int OP_LSB  = 20;
  localparam int RD_MSB  = 19;
  localparam int RD_LSB  = 16;
  localparam int RN_MSB  = 15;
  localparam int RN_LSB  = 12;
  localparam int RM_MSB  = 11;
  localparam int RM_LSB  = 8;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_ADDI = 4'h4,
    OP_SUBI = 4'h5,
    OP_MOVI = 4'h6,
    OP_BEQZ = 4'h7,
    OP_B    = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_WB     = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/asip_regfile.sv
// rtl/asip_regfile.sv - register file with two async read ports and one sync write port
//
// Purpose: NREGS x DATA_W architectural registers. r0 and indices >= NREGS
//          read as zero; writes to them are dropped. Synchronous reset to 0.
// Ports:   clk, rst          - clock, synchronous active-high reset
//          i_we, i_waddr,
//          i_wdata           - write port (takes effect on rising edge)
//          i_raddr_a/b       - read addresses
//          o_rdata_a/b       - combinational read data

module asip_regfile
  import asip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [3:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [3:0]        i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam logic [4:0] LP_NREGS = 5'(NREGS);

  // Full 16-entry array keeps indexing width-clean; entries at or above
  // NREGS are never written and so stay constant zero.
  logic [DATA_W-1:0] r_regs [16];

  logic w_wr_ok;
  logic w_rd_ok_a;
  logic w_rd_ok_b;

  assign w_wr_ok   = i_we && (i_waddr != 4'd0) && ({1'b0, i_waddr} < LP_NREGS);
  assign w_rd_ok_a = (i_raddr_a != 4'd0) && ({1'b0, i_raddr_a} < LP_NREGS);
  assign w_rd_ok_b = (i_raddr_b != 4'd0) && ({1'b0, i_raddr_b} < LP_NREGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = w_rd_ok_a ? r_regs[i_raddr_a] : '0;
  assign o_rdata_b = w_rd_ok_b ? r_regs[i_raddr_b] : '0;

endmodule

// File: rtl/asip_mc.sv
// rtl/asip_mc.sv - multicycle ASIP core top (FETCH/EXEC/WB/HALTED)
//
// Purpose: fetches 24-bit instructions with a request/valid handshake and
//          executes ALU, immediate, branch and HALT instructions over at
//          least three cycles each.
// Ports:   clk, rst     - clock, synchronous active-high reset
//          inst_req     - core wants the instruction at PC (high in FETCH)
//          inst_valid   - inst holds the instruction for PC
//          inst         - instruction word
//          PC           - address of instruction being fetched/executed
//          aluRes       - result of last ALU/MOVI operation
//          aluZero      - aluRes == 0 for last ALU/MOVI operation
//          halted       - core is in HALTED

module asip_mc
  import asip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter int NREGS  = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              inst_req,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] aluRes,
  output logic              aluZero,
  output logic              halted
);

  state_e              r_state;
  logic [INST_W-1:0]   r_ir;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_pc_next;
  logic [DATA_W-1:0]   r_res;
  logic [DATA_W-1:0]   r_alu_res;
  logic                r_alu_zero;
  logic                r_is_alu;
  logic                r_inst_req;
  logic                r_halted;

  opcode_e             w_op;
  logic [3:0]          w_rd;
  logic [3:0]          w_rn;
  logic [3:0]          w_rm;
  logic [11:0]         w_imm12;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_alu;
  logic                w_is_alu;
  logic [PC_W-1:0]     w_pc_seq;
  logic [PC_W-1:0]     w_pc_br;
  logic [PC_W-1:0]     w_pc_next;
  logic                w_we;

  assign w_op    = opcode_e'(r_ir[OP_MSB:OP_LSB]);
  assign w_rd    = r_ir[RD_MSB:RD_LSB];
  assign w_rn    = r_ir[RN_MSB:RN_LSB];
  assign w_rm    = r_ir[RM_MSB:RM_LSB];
  assign w_imm12 = r_ir[IMM_MSB:IMM_LSB];

  // Size casts zero-extend or truncate the immediate to the datapath width;
  // the signed cast sign-extends the branch offset to PC width.
  assign w_imm    = DATA_W'(w_imm12);
  assign w_pc_seq = r_pc + PC_W'(1);
  assign w_pc_br  = w_pc_seq + PC_W'($signed(w_imm12));

  // IR is stable from EXEC through WB, so rd can come straight from it.
  assign w_we = (r_state == ST_WB) && r_is_alu;

  asip_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_rd),
    .i_wdata   (r_res),
    .i_raddr_a (w_rn),
    .o_rdata_a (w_a),
    .i_raddr_b (w_rm),
    .o_rdata_b (w_b)
  );

  always_comb begin
    w_alu     = '0;
    w_is_alu  = 1'b1;
    w_pc_next = w_pc_seq;
    case (w_op)
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_ADDI: w_alu = w_a + w_imm;
      OP_SUBI: w_alu = w_a - w_imm;
      OP_MOVI: w_alu = w_imm;
      OP_BEQZ: begin
        w_is_alu = 1'b0;
        if (w_a == '0) w_pc_next = w_pc_br;
      end
      OP_B: begin
        w_is_alu  = 1'b0;
        w_pc_next = w_pc_br;
      end
      default: w_is_alu = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_ir       <= '0;
      r_pc       <= '0;
      r_pc_next  <= '0;
      r_res      <= '0;
      r_alu_res  <= '0;
      r_alu_zero <= 1'b1;
      r_is_alu   <= 1'b0;
      r_inst_req <= 1'b1;
      r_halted   <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (inst_valid) begin
            r_ir       <= inst;
            r_state    <= ST_EXEC;
            r_inst_req <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (w_op == OP_HALT) begin
            r_state  <= ST_HALTED;
            r_halted <= 1'b1;
          end else begin
            r_res     <= w_alu;
            r_pc_next <= w_pc_next;
            r_is_alu  <= w_is_alu;
            r_state   <= ST_WB;
          end
        end
        ST_WB: begin
          if (r_is_alu) begin
            r_alu_res  <= r_res;
            r_alu_zero <= (r_res == '0);
          end
          r_pc       <= r_pc_next;
          r_state    <= ST_FETCH;
          r_inst_req <= 1'b1;
        end
        ST_HALTED: begin
          r_inst_req <= 1'b0;
          r_halted   <= 1'b1;
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign inst_req = r_inst_req;
  assign PC       = r_pc;
  assign aluRes   = r_alu_res;
  assign aluZero  = r_alu_zero;
  assign halted   = r_halted;

endmodule

// File: tb/tb_asip_mc.sv
// tb/tb_asip_mc.sv - self-checking bench for asip_mc (16-bit and 8-bit instances)

module tb_asip_mc;

  logic        clk;
  logic        rst_a, rst_b;
  logic        valid_a, valid_b;
  logic [23:0] inst_a, inst_b;
  logic        req_a, req_b;
  logic [15:0] pc_a;
  logic [7:0]  pc_b;
  logic [15:0] res_a;
  logic [7:0]  res_b;
  logic        z_a, z_b;
  logic        halt_a, halt_b;

  int n_checks = 0;
  int n_errors = 0;

  asip_mc #(.DATA_W(16), .PC_W(16), .NREGS(16)) u_dut16 (
    .clk        (clk),
    .rst        (rst_a),
    .inst_req   (req_a),
    .inst_valid (valid_a),
    .inst       (inst_a),
    .PC         (pc_a),
    .aluRes     (res_a),
    .aluZero    (z_a),
    .halted     (halt_a)
  );

  asip_mc #(.DATA_W(8), .PC_W(8), .NREGS(4)) u_dut8 (
    .clk        (clk),
    .rst        (rst_b),
    .inst_req   (req_b),
    .inst_valid (valid_b),
    .inst       (inst_b),
    .PC         (pc_b),
    .aluRes     (res_b),
    .aluZero    (z_b),
    .halted     (halt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    logic [23:0] ins;
    logic [15:0] exp_res;
    logic        exp_z;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [22];

  function automatic logic [15:0] get_pc(input int d);
    return (d == 0) ? pc_a : {8'h00, pc_b};
  endfunction

  function automatic logic [15:0] get_res(input int d);
    return (d == 0) ? res_a : {8'h00, res_b};
  endfunction

  function automatic logic get_z(input int d);
    return (d == 0) ? z_a : z_b;
  endfunction

  function automatic logic get_req(input int d);
    return (d == 0) ? req_a : req_b;
  endfunction

  function automatic logic get_halt(input int d);
    return (d == 0) ? halt_a : halt_b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [23:0] ins);
    if (d == 0) begin
      valid_a = v;
      inst_a  = ins;
    end else begin
      valid_b = v;
      inst_b  = ins;
    end
  endtask

  // Present one instruction in FETCH and wait until the core is back in FETCH.
  task automatic run_instr(input int d, input logic [23:0] ins, output int cyc);
    cyc = 0;
    drive(d, 1'b1, ins);
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) drive(d, 1'b0, 24'h0);
    end while (!get_req(d) && cyc < 20);
  endtask

  initial begin
    int cyc;

    //                dut  inst          aluRes    Z     PC
    vecs[0]  = '{0, 24'h610005, 16'h0005, 1'b0, 16'h0001}; // MOVI r1,5
    vecs[1]  = '{0, 24'h421003, 16'h0008, 1'b0, 16'h0002}; // ADDI r2,r1,3
    vecs[2]  = '{0, 24'h131100, 16'h0000, 1'b1, 16'h0003}; // SUB r3,r1,r1
    vecs[3]  = '{0, 24'h042100, 16'h000D, 1'b0, 16'h0004}; // ADD r4,r2,r1
    vecs[4]  = '{0, 24'h700FFE, 16'h000D, 1'b0, 16'h0003}; // BEQZ r0,-2 taken
    vecs[5]  = '{0, 24'h254200, 16'h0008, 1'b0, 16'h0004}; // AND r5,r4,r2
    vecs[6]  = '{0, 24'h364100, 16'h000D, 1'b0, 16'h0005}; // OR r6,r4,r1
    vecs[7]  = '{0, 24'h571006, 16'hFFFF, 1'b0, 16'h0006}; // SUBI r7,r1,6
    vecs[8]  = '{0, 24'h701005, 16'hFFFF, 1'b0, 16'h0007}; // BEQZ r1 not taken
    vecs[9]  = '{0, 24'h9ABCDE, 16'hFFFF, 1'b0, 16'h0008}; // NOP (op 9)
    vecs[10] = '{0, 24'h600123, 16'h0123, 1'b0, 16'h0009}; // MOVI r0 (dropped)
    vecs[11] = '{0, 24'h080000, 16'h0000, 1'b1, 16'h000A}; // ADD r8,r0,r0
    vecs[12] = '{0, 24'h690FFF, 16'h0FFF, 1'b0, 16'h000B}; // MOVI r9,0xFFF
    vecs[13] = '{0, 24'h499FFF, 16'h1FFE, 1'b0, 16'h000C}; // ADDI r9,r9,0xFFF
    vecs[14] = '{0, 24'h800FF2, 16'h1FFE, 1'b0, 16'hFFFF}; // B -14
    vecs[15] = '{0, 24'h800001, 16'h1FFE, 1'b0, 16'h0001}; // B +1 wraps
    vecs[16] = '{0, 24'h0A9300, 16'h1FFE, 1'b0, 16'h0002}; // ADD r10,r9,r3
    vecs[17] = '{1, 24'h6100FF, 16'h00FF, 1'b0, 16'h0001}; // MOVI r1,0xFF
    vecs[18] = '{1, 24'h411001, 16'h0000, 1'b1, 16'h0002}; // ADDI r1,r1,1
    vecs[19] = '{1, 24'h620ABC, 16'h00BC, 1'b0, 16'h0003}; // MOVI r2, trunc
    vecs[20] = '{1, 24'h650007, 16'h0007, 1'b0, 16'h0004}; // MOVI r5 (>=NREGS)
    vecs[21] = '{1, 24'h035200, 16'h00BC, 1'b0, 16'h0005}; // ADD r3,r5,r2

    rst_a = 1'b1; rst_b = 1'b1;
    drive(0, 1'b0, 24'h0);
    drive(1, 1'b0, 24'h0);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_pc%0d", d),   32'(get_pc(d)),   32'h0);
      chk($sformatf("rst_res%0d", d),  32'(get_res(d)),  32'h0);
      chk($sformatf("rst_z%0d", d),    32'(get_z(d)),    32'h1);
      chk($sformatf("rst_halt%0d", d), 32'(get_halt(d)), 32'h0);
      chk($sformatf("rst_req%0d", d),  32'(get_req(d)),  32'h1);
    end
    rst_a = 1'b0; rst_b = 1'b0;

    for (int i = 0; i < 22; i++) begin
      run_instr(vecs[i].dut, vecs[i].ins, cyc);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'd3);
      chk($sformatf("v%0d_res", i), 32'(get_res(vecs[i].dut)), 32'(vecs[i].exp_res));
      chk($sformatf("v%0d_z", i),   32'(get_z(vecs[i].dut)),   32'(vecs[i].exp_z));
      chk($sformatf("v%0d_pc", i),  32'(get_pc(vecs[i].dut)),  32'(vecs[i].exp_pc));
    end

    // FETCH stall: nothing moves while inst_valid is low.
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d_req", k), 32'(req_a), 32'h1);
      chk($sformatf("stall%0d_pc", k),  32'(pc_a),  32'h0002);
      chk($sformatf("stall%0d_res", k), 32'(res_a), 32'h1FFE);
    end
    run_instr(0, 24'h0BA000, cyc); // ADD r11,r10,r0
    chk("post_stall_cycles", 32'(cyc), 32'd3);
    chk("post_stall_res", 32'(res_a), 32'h1FFE);
    chk("post_stall_pc", 32'(pc_a), 32'h0003);

    // HALT, then keep offering an instruction that must be ignored.
    drive(0, 1'b1, 24'hF00000);
    @(posedge clk); #1;
    drive(0, 1'b1, 24'h610009);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("halt%0d_halted", k), 32'(halt_a), 32'h1);
      chk($sformatf("halt%0d_req", k),    32'(req_a),  32'h0);
      chk($sformatf("halt%0d_pc", k),     32'(pc_a),   32'h0003);
      chk($sformatf("halt%0d_res", k),    32'(res_a),  32'h1FFE);
      @(posedge clk); #1;
    end

    // Leave HALTED via reset.
    drive(0, 1'b0, 24'h0);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("unhalt_halted", 32'(halt_a), 32'h0);
    chk("unhalt_req", 32'(req_a), 32'h1);

    // Reset pulse while MOVI r1,7 is in EXEC.
    drive(0, 1'b1, 24'h610007);
    @(posedge clk); #1;
    drive(0, 1'b0, 24'h0);
    chk("exec_req_low", 32'(req_a), 32'h0);
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("abort_pc", 32'(pc_a), 32'h0);
    chk("abort_req", 32'(req_a), 32'h1);
    chk("abort_res", 32'(res_a), 32'h0);
    chk("abort_z", 32'(z_a), 32'h1);
    // Wait two more cycles: an aborted WB must not surface late.
    repeat (2) @(posedge clk);
    #1;
    chk("abort_pc_late", 32'(pc_a), 32'h0);
    chk("abort_res_late", 32'(res_a), 32'h0);
    run_instr(0, 24'h021000, cyc); // ADD r2,r1,r0 -> r1 must be 0
    chk("abort_r1_res", 32'(res_a), 32'h0);
    chk("abort_r1_z", 32'(z_a), 32'h1);
    chk("abort_r1_pc", 32'(pc_a), 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
